pci_bus_arbiter: RTL and testbench
==================================

// Module: pci_bus_arbiter
// PURPOSE
//   Central PCI bus arbiter for the AmigaPCI board. Shares the PCI AD/FRAME bus among the bridge
//   (the 68040-side PCI master) and the slot masters. Samples active-low nREQ lines, drives one
//   active-low nGNT at a time and uses round-robin fairness. Parks the bus on the bridge when idle.
//   Monitors nFRAME/nIRDY so a grant only changes owner on an idle bus, or pre-empts a busy owner.
// PARAMETERS
//   NREQ          4    number of requesters; index 0..NREQ-1, NREQ range 2..8
//   PARK          0    requester index parked on when no requests (bridge = 0)
//   GNT_TIMEOUT   16   idle clocks a granted master may take to assert nFRAME before revoke (2..255)
// PORTS
//   PCICLK        in   1       PCI clock; all state on rising edge
//   nRESET        in   1       asynchronous active-low reset
//   nREQ          in   NREQ    active-low bus requests, already synchronous to PCICLK
//   nFRAME        in   1       PCI FRAME#, sampled
//   nIRDY         in   1       PCI IRDY#, sampled
//   nGNT          out  NREQ    active-low grants; at most one low in any clock
//   OWNER         out  3       index of current/last granted master
//   BUS_BUSY      out  1       1 while a granted transaction is in progress (state BUSY)
//   TIMEOUT_ERR   out  1       one-clock pulse when a grant is revoked for GNT_TIMEOUT
// BEHAVIOUR
//   - Reset (async): nGNT all 1, OWNER=PARK, BUS_BUSY=0, TIMEOUT_ERR=0, RR pointer=PARK, state=IDLE,
//     timeout counter=0. Reset mid-transaction drops every grant in the same instant.
//   - All outputs registered. A request sampled on edge k gives nGNT low at the earliest after edge k+1.
//   - IDLE_BUS = nFRAME & nIRDY (both sampled high).
//   - Winner selection: round-robin. Search starts at RR pointer+1 and wraps modulo NREQ. The first
//     requester with nREQ=0 wins. RR pointer := winner when its grant starts.
//   - States:
//     IDLE  : no requests -> nGNT[PARK]=0 (parked), OWNER=PARK. When any request arrives:
//             - if the winner == PARK, go to GRANTED with no gap;
//             - otherwise go to TURN.
//     TURN  : all nGNT=1 for exactly one clock. Next state GRANTED with the winner latched on
//             entry to TURN.
//     GRANTED: nGNT[OWNER]=0, counter +1 per clock while IDLE_BUS.
//             - nFRAME=0 sampled -> BUSY and clear counter.
//             - owner drops nREQ before FRAME -> IDLE if no other request, else TURN.
//             - counter == GNT_TIMEOUT-1 with bus idle -> pulse TIMEOUT_ERR, go to TURN, and the
//               next winner excludes the revoked owner for this pass.
//             - nFRAME=0 on the same edge as timeout: FRAME wins, no error.
//     BUSY  : BUS_BUSY=1.
//             - If any other nREQ=0, deassert nGNT[OWNER] next clock (pre-emption). The master
//               finishes on its latency timer; the arbiter never forces FRAME.
//             - Otherwise keep nGNT[OWNER]=0, which allows back-to-back transactions without a gap.
//             - On IDLE_BUS: go to IDLE if no requests; go to GRANTED if the owner still holds the
//               grant and is the only requester; otherwise go to TURN.
//             - Owner re-starts FRAME while still granted: stay in BUSY.
//   - Invariant: never two nGNT low. Never switch from one low nGNT to a different low nGNT
//     without one all-high clock.
//   - OWNER width is fixed at 3. Upper bits are 0 when NREQ<8.
// TESTING
//   1 Reset release, no requests -> after 1st edge nGNT=4'b1110 (parked on 0), OWNER=0, BUS_BUSY=0.
//   2 nREQ=4'b1011 from park -> one clock nGNT=4'b1111, then nGNT=4'b1011; FRAME low -> BUS_BUSY=1.
//   3 nREQ 1,2,3 held low together, each master runs one transaction -> grant order 1,2,3,1 with one
//     all-high clock between owners.
//   4 Master 2 granted, never drives FRAME -> after 16 idle clocks TIMEOUT_ERR pulses once, all
//     grants high 1 clock, grant moves to the next requester or to park.
//   5 Master 1 BUSY, master 3 raises request -> nGNT[1] high next clock while FRAME still low;
//     nGNT[3] low only after IDLE_BUS plus the TURN clock.
//   6 nRESET low during BUSY -> nGNT=4'b1111 immediately; after release parks on 0; check with
//     an assertion every clock that at most one grant is low.

Source files
------------

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grant of the shared PCI bus among
// NREQ masters, parked on PARK when idle, with grant timeout and pre-emption.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no grant in progress; bus parked on PARK
// TURN    | one all-high nGNT clock before handing the bus to a new owner
// GRANTED | owner holds nGNT, waiting for FRAME; timeout counter runs
// BUSY    | owner's transaction in progress
module pci_bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int PARK        = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic            PCICLK,
  input  logic            nRESET,
  input  logic [NREQ-1:0] nREQ,
  input  logic            nFRAME,
  input  logic            nIRDY,
  output logic [NREQ-1:0] nGNT,
  output logic [2:0]      OWNER,
  output logic            BUS_BUSY,
  output logic            TIMEOUT_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_GRANTED, S_BUSY} state_t;

  localparam logic [NREQ-1:0] ONE       = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [2:0]      PARK_IDX  = 3'(PARK);
  localparam logic [NREQ-1:0] PARK_NGNT = ~(ONE << PARK);
  localparam logic [7:0]      CNT_LAST  = 8'(GNT_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] ngnt_q, ngnt_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      rr_q, rr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            busy_d, terr_d;

  logic [NREQ-1:0] req, owner_mask, idle_ngnt;
  logic            any_req, idle_bus, owner_req, others_req, owner_granted;
  logic [3:0]      win, win_x;

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] idx);
    return ONE << idx;
  endfunction

  // Returns {found, index}: first requester after ptr, wrapping modulo NREQ.
  function automatic logic [3:0] pick(input logic [NREQ-1:0] r, input logic [2:0] ptr);
    logic [3:0]      res;
    logic [NREQ-1:0] sh;
    int              j;
    res = 4'b0;
    for (int i = NREQ; i >= 1; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      sh = r >> j;
      if (sh[0]) res = {1'b1, j[2:0]};
    end
    return res;
  endfunction

  assign req           = ~nREQ;
  assign any_req       = |req;
  assign idle_bus      = nFRAME & nIRDY;
  assign owner_mask    = onehot(owner_q);
  assign owner_req     = |(req & owner_mask);
  assign others_req    = |(req & ~owner_mask);
  assign owner_granted = |(~ngnt_q & owner_mask);
  assign win           = pick(req, rr_q);
  assign win_x         = pick(req & ~owner_mask, rr_q);
  // Dropping to IDLE keeps the park grant only if it is already the live grant;
  // any other owner gets one all-high clock first.
  assign idle_ngnt     = (ngnt_q == PARK_NGNT) ? PARK_NGNT : '1;

  // State and registered outputs.
  always_ff @(posedge PCICLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      ngnt_q      <= '1;
      owner_q     <= PARK_IDX;
      rr_q        <= PARK_IDX;
      cnt_q       <= '0;
      BUS_BUSY    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state_q     <= state_d;
      ngnt_q      <= ngnt_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      BUS_BUSY    <= busy_d;
      TIMEOUT_ERR <= terr_d;
    end
  end

  // Next-state, grant and counter logic.
  always_comb begin
    state_d = state_q;
    ngnt_d  = ngnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        owner_d = PARK_IDX;
        if (!any_req) begin
          ngnt_d = PARK_NGNT;
        end else if (win[2:0] == PARK_IDX) begin
          state_d = S_GRANTED;
          ngnt_d  = PARK_NGNT;
          rr_d    = PARK_IDX;
          cnt_d   = '0;
        end else begin
          state_d = S_TURN;
          ngnt_d  = '1;
          owner_d = win[2:0];
        end
      end
      S_TURN: begin
        state_d = S_GRANTED;
        ngnt_d  = ~onehot(owner_q);
        rr_d    = owner_q;
        cnt_d   = '0;
      end
      S_GRANTED: begin
        if (!nFRAME) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end else if (!owner_req) begin
          if (!any_req) begin
            state_d = S_IDLE;
            ngnt_d  = idle_ngnt;
            owner_d = PARK_IDX;
          end else begin
            state_d = S_TURN;
            ngnt_d  = '1;
            owner_d = win[2:0];
          end
        end else if (idle_bus) begin
          if (cnt_q == CNT_LAST) begin
            // Revoke: the timed-out owner sits out this pass.
            terr_d  = 1'b1;
            state_d = S_TURN;
            ngnt_d  = '1;
            owner_d = win_x[3] ? win_x[2:0] : PARK_IDX;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_BUSY: begin
        if (idle_bus) begin
          if (!any_req) begin
            state_d = S_IDLE;
            ngnt_d  = idle_ngnt;
            owner_d = PARK_IDX;
          end else if (owner_granted && owner_req && !others_req) begin
            state_d = S_GRANTED;
            cnt_d   = '0;
          end else begin
            state_d = S_TURN;
            ngnt_d  = '1;
            owner_d = win[2:0];
          end
        end else if (others_req) begin
          // Pre-empt: the owner finishes on its own latency timer.
          ngnt_d = '1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ngnt_d  = '1;
        owner_d = PARK_IDX;
      end
    endcase
    busy_d = (state_d == S_BUSY);
  end

  assign nGNT  = ngnt_q;
  assign OWNER = owner_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (NREQ=4, PARK=0, GNT_TIMEOUT=16).
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] nreq = 4'hF;
  logic       nframe = 1'b1;
  logic       nirdy = 1'b1;
  logic [3:0] ngnt;
  logic [2:0] owner;
  logic       busy;
  logic       terr;

  int errors = 0;
  int checks = 0;
  logic [3:0] prev_ngnt = 4'hF;

  pci_bus_arbiter #(.NREQ(4), .PARK(0), .GNT_TIMEOUT(16)) dut (
    .PCICLK(clk), .nRESET(rst_n), .nREQ(nreq), .nFRAME(nframe), .nIRDY(nirdy),
    .nGNT(ngnt), .OWNER(owner), .BUS_BUSY(busy), .TIMEOUT_ERR(terr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~ngnt))
    else $error("FAIL one_gnt assertion nGNT=%b", ngnt);

  // Every clock: at most one grant, and never a direct switch between two owners.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_gnt", 32'($countones(~ngnt) <= 1), 32'd1);
      if (prev_ngnt != 4'hF && ngnt != 4'hF) chk("gap", 32'(ngnt), 32'(prev_ngnt));
    end
    prev_ngnt = ngnt;
  end

  task automatic do_reset();
    rst_n = 1'b0; nreq = 4'hF; nframe = 1'b1; nirdy = 1'b1;
    tick();
    chk("rst_ngnt", 32'(ngnt), 32'hF);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(terr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("park_ngnt", 32'(ngnt), 32'hE);
    chk("park_owner", 32'(owner), 32'd0);
    chk("park_busy", 32'(busy), 32'd0);
  endtask

  // One transaction by master m; pre says whether other requests are pending.
  task automatic txn(input int m, input logic pre);
    logic [3:0] exp_g;
    bit seen;
    exp_g = ~(4'b0001 << m);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (ngnt == exp_g) seen = 1'b1;
      else tick();
    end
    chk("grant_wait", 32'(seen), 32'd1);
    chk("grant_ngnt", 32'(ngnt), 32'(exp_g));
    chk("grant_owner", 32'(owner), 32'(m));
    nframe = 1'b0; nirdy = 1'b0;
    tick();
    chk("busy_set", 32'(busy), 32'd1);
    chk("busy_hold", 32'(ngnt), 32'(exp_g));
    tick();
    chk("preempt", 32'(ngnt), pre ? 32'hF : 32'(exp_g));
    nframe = 1'b1;
    tick();
    nirdy = 1'b1;
    tick();
    chk("busy_end", 32'(busy), 32'd0);
    if (pre) chk("turn", 32'(ngnt), 32'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset and parking; request from the park master is granted with no gap
    do_reset();
    nreq = 4'b1110;
    tick();
    chk("park_req_ngnt", 32'(ngnt), 32'hE);
    nframe = 1'b0; nirdy = 1'b0;
    tick();
    chk("park_busy", 32'(busy), 32'd1);
    nreq = 4'hF; nframe = 1'b1;
    tick();
    nirdy = 1'b1;
    tick();
    chk("park_end_ngnt", 32'(ngnt), 32'hE);
    chk("park_end_busy", 32'(busy), 32'd0);

    // 2: master 2 from park: one all-high clock, then grant, then BUSY
    nreq = 4'b1011;
    tick();
    chk("t2_turn", 32'(ngnt), 32'hF);
    tick();
    chk("t2_gnt", 32'(ngnt), 32'hB);
    chk("t2_owner", 32'(owner), 32'd2);
    nframe = 1'b0; nirdy = 1'b0;
    tick();
    chk("t2_busy", 32'(busy), 32'd1);
    nreq = 4'hF; nframe = 1'b1;
    tick();
    chk("t2_hold", 32'(ngnt), 32'hB);
    nirdy = 1'b1;
    tick();
    chk("t2_gap", 32'(ngnt), 32'hF);
    chk("t2_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("t2_park", 32'(ngnt), 32'hE);

    // 3: masters 1,2,3 together -> order 1,2,3,1
    do_reset();
    nreq = 4'b0001;
    txn(1, 1'b1);
    txn(2, 1'b1);
    txn(3, 1'b1);
    txn(1, 1'b1);
    nreq = 4'hF;

    // 4: master 2 never drives FRAME; master 3 also waiting
    do_reset();
    nreq = 4'b0011;
    tick();
    chk("t4_turn", 32'(ngnt), 32'hF);
    tick();
    chk("t4_gnt", 32'(ngnt), 32'hB);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_no_to", 32'(terr), 32'd0);
    end
    chk("t4_still", 32'(ngnt), 32'hB);
    tick();
    chk("t4_terr", 32'(terr), 32'd1);
    chk("t4_revoke", 32'(ngnt), 32'hF);
    chk("t4_next_owner", 32'(owner), 32'd3);
    tick();
    chk("t4_terr_pulse", 32'(terr), 32'd0);
    chk("t4_gnt3", 32'(ngnt), 32'h7);
    nreq = 4'hF;
    tick();
    chk("t4_gap", 32'(ngnt), 32'hF);
    tick();
    chk("t4_park", 32'(ngnt), 32'hE);

    // FRAME on the timeout edge wins; owner alone re-granted without gap
    do_reset();
    nreq = 4'b1011;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    nframe = 1'b0; nirdy = 1'b0;
    tick();
    chk("tf_terr", 32'(terr), 32'd0);
    chk("tf_busy", 32'(busy), 32'd1);
    chk("tf_gnt", 32'(ngnt), 32'hB);
    nframe = 1'b1;
    tick();
    nirdy = 1'b1;
    tick();
    chk("tf_regrant", 32'(ngnt), 32'hB);
    chk("tf_busy_off", 32'(busy), 32'd0);
    nreq = 4'hF;
    tick();
    chk("tf_gap", 32'(ngnt), 32'hF);
    tick();
    chk("tf_park", 32'(ngnt), 32'hE);

    // 5: master 1 busy alone, master 3 arrives -> pre-emption
    do_reset();
    nreq = 4'b1101;
    tick();
    tick();
    chk("t5_gnt", 32'(ngnt), 32'hD);
    nframe = 1'b0; nirdy = 1'b0;
    tick();
    tick();
    chk("t5_b2b", 32'(ngnt), 32'hD);
    nreq = 4'b0101;
    tick();
    chk("t5_preempt", 32'(ngnt), 32'hF);
    chk("t5_busy", 32'(busy), 32'd1);
    nframe = 1'b1; nreq = 4'b0111;
    tick();
    chk("t5_wait", 32'(ngnt), 32'hF);
    nirdy = 1'b1;
    tick();
    chk("t5_turn", 32'(ngnt), 32'hF);
    chk("t5_owner", 32'(owner), 32'd3);
    tick();
    chk("t5_gnt3", 32'(ngnt), 32'h7);
    nreq = 4'hF;
    tick();
    chk("t5_gap", 32'(ngnt), 32'hF);
    tick();
    chk("t5_park", 32'(ngnt), 32'hE);

    // 6: reset asserted mid-transaction
    do_reset();
    nreq = 4'b1101;
    tick();
    tick();
    nframe = 1'b0; nirdy = 1'b0;
    tick();
    chk("t6_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_drop", 32'(ngnt), 32'hF);
    chk("t6_busy_clr", 32'(busy), 32'd0);
    chk("t6_owner", 32'(owner), 32'd0);
    nreq = 4'hF; nframe = 1'b1; nirdy = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_park", 32'(ngnt), 32'hE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
